// File: rtl/fp_mult_arbiter.sv
// Round-robin arbiter sharing one combinational IEEE-754 single multiplier between two requesters.
// Operands are registered at grant, the product is captured after MC_CYCLES and held until the owner accepts it.

module multiplier (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] p_o,
  output logic        ovf_o,
  output logic        unf_o
);
  logic               sp;
  logic [7:0]         ea, eb;
  logic [23:0]        ma, mb;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [47:0]        prod;
  logic [22:0]        frac;
  logic               guard, sticky, inc;
  logic [23:0]        frac_r;
  logic signed [10:0] exp_s;

  assign sp     = a_i[31] ^ b_i[31];
  assign ea     = a_i[30:23];
  assign eb     = b_i[30:23];
  assign ma     = {1'b1, a_i[22:0]};
  assign mb     = {1'b1, b_i[22:0]};
  // Subnormal inputs are flushed to zero.
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);
  assign a_inf  = (ea == 8'hFF) && (a_i[22:0] == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (b_i[22:0] == 23'd0);
  assign a_nan  = (ea == 8'hFF) && (a_i[22:0] != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (b_i[22:0] != 23'd0);

  always_comb begin
    p_o   = 32'd0;
    ovf_o = 1'b0;
    unf_o = 1'b0;
    prod  = 48'(ma) * 48'(mb);
    if (prod[47]) begin
      frac   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end else begin
      frac   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    // Round to nearest, ties to even; a carry out renormalises to the next binade.
    inc    = guard & (sticky | frac[0]);
    frac_r = {1'b0, frac} + {23'd0, inc};
    exp_s  = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 11'sd127
           + $signed({10'd0, prod[47]}) + $signed({10'd0, frac_r[23]});

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      p_o = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      p_o = {sp, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      p_o = {sp, 31'd0};
    end else if (exp_s >= 11'sd255) begin
      p_o   = {sp, 8'hFF, 23'd0};
      ovf_o = 1'b1;
    end else if (exp_s <= 11'sd0) begin
      p_o   = {sp, 31'd0};
      unf_o = 1'b1;
    end else begin
      p_o = {sp, exp_s[7:0], frac_r[22:0]};
    end
  end
endmodule

module fp_mult_arbiter #(
  parameter int unsigned MC_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_overflow,
  output logic        rsp_underflow,
  output logic        busy,
  input  logic        clr_flags,
  output logic        sticky_ovf,
  output logic        sticky_unf
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MC_CYCLES - 1);

  state_t      state_q;
  logic        prio_q, owner_q;
  logic [3:0]  cnt_q;
  logic [31:0] op_a_q, op_b_q;
  logic [31:0] res_q;
  logic        ovf_q, unf_q;
  logic        rsp0_vld_q, rsp1_vld_q;
  logic        sticky_ovf_q, sticky_unf_q;
  logic        sticky_ovf_d, sticky_unf_d;
  logic        gnt0, gnt1, capture, owner_ack;
  logic [31:0] mul_p;
  logic        mul_ovf, mul_unf;

  multiplier u_multiplier (
    .a_i   (op_a_q),
    .b_i   (op_b_q),
    .p_o   (mul_p),
    .ovf_o (mul_ovf),
    .unf_o (mul_unf)
  );

  // prio_q names the requester that wins a tie.
  assign gnt0       = req0_valid & (~req1_valid | ~prio_q);
  assign gnt1       = req1_valid & (~req0_valid |  prio_q);
  assign req0_ready = (state_q == IDLE) & ~rst & gnt0;
  assign req1_ready = (state_q == IDLE) & ~rst & gnt1;
  assign capture    = (state_q == EXEC) && (cnt_q == 4'd0);
  assign owner_ack  = owner_q ? rsp1_ready : rsp0_ready;

  // A capture coinciding with a clear keeps only the freshly captured flags.
  always_comb begin
    sticky_ovf_d = sticky_ovf_q;
    sticky_unf_d = sticky_unf_q;
    if (clr_flags) begin
      sticky_ovf_d = 1'b0;
      sticky_unf_d = 1'b0;
    end
    if (capture) begin
      sticky_ovf_d = sticky_ovf_d | mul_ovf;
      sticky_unf_d = sticky_unf_d | mul_unf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      owner_q      <= 1'b0;
      cnt_q        <= 4'd0;
      res_q        <= 32'd0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      rsp0_vld_q   <= 1'b0;
      rsp1_vld_q   <= 1'b0;
      sticky_ovf_q <= 1'b0;
      sticky_unf_q <= 1'b0;
    end else begin
      sticky_ovf_q <= sticky_ovf_d;
      sticky_unf_q <= sticky_unf_d;
      case (state_q)
        IDLE: begin
          if (gnt0 || gnt1) begin
            op_a_q  <= gnt1 ? req1_a : req0_a;
            op_b_q  <= gnt1 ? req1_b : req0_b;
            owner_q <= gnt1;
            prio_q  <= ~gnt1;
            cnt_q   <= CNT_INIT;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            res_q <= mul_p;
            ovf_q <= mul_ovf;
            unf_q <= mul_unf;
            if (owner_q) rsp1_vld_q <= 1'b1;
            else         rsp0_vld_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (owner_ack) begin
            rsp0_vld_q <= 1'b0;
            rsp1_vld_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp0_valid    = rsp0_vld_q;
  assign rsp1_valid    = rsp1_vld_q;
  assign rsp_result    = res_q;
  assign rsp_overflow  = ovf_q;
  assign rsp_underflow = unf_q;
  assign busy          = (state_q != IDLE);
  assign sticky_ovf    = sticky_ovf_q;
  assign sticky_unf    = sticky_unf_q;
endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Self-checking bench for fp_mult_arbiter: directed vector table, hand-written corner sequences,
// and random traffic checked against a real-arithmetic product model and a round-robin model.

module tb_fp_mult_arbiter;
  localparam int MC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp_result;
  logic        rsp_overflow, rsp_underflow, busy, clr_flags, sticky_ovf, sticky_unf;

  always #5 clk = ~clk;

  fp_mult_arbiter #(.MC_CYCLES(MC)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow), .rsp_underflow(rsp_underflow),
    .busy(busy), .clr_flags(clr_flags), .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        o;
    logic        u;
  } vec_t;

  vec_t        vt[10];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          next_pref;
  int          last_wait;
  logic        exp_sov, exp_sun;
  logic [31:0] ra[2], rb[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Widen a single-precision value to double; exact for normal numbers and zero.
  function automatic logic [63:0] s2d(input logic [31:0] s);
    if (s[30:0] == 31'd0) return {s[31], 63'd0};
    return {s[31], 11'({3'b000, s[30:23]} + 11'd896), s[22:0], 29'd0};
  endfunction

  // Product via real arithmetic; operands used here have 12-bit significands, so it is exact.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    real         p;
    logic [63:0] d;
    p = $bitstoreal(s2d(a)) * $bitstoreal(s2d(b));
    d = $realtobits(p);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] rnd_fp();
    return {1'($urandom), 8'($urandom_range(100, 150)), 11'($urandom), 12'd0};
  endfunction

  // Waits for the grant to idx, follows the operation to its response, then accepts it after bp cycles.
  task automatic serve(input int idx, input logic [31:0] er, input logic eo, input logic eu,
                       input logic clr_cap, input int bp);
    int          waited, lat, d;
    logic        got;
    logic [31:0] held;
    got    = 1'b0;
    waited = 0;
    while (!got && waited < 20) begin
      #1;
      if (req0_ready || req1_ready) got = 1'b1;
      else begin
        tick();
        waited++;
      end
    end
    check("grant_seen", 32'(got), 32'd1);
    if (!got) return;
    last_wait = waited;
    check("grant_idx", 32'(req1_ready), 32'(idx));
    check("grant_onehot", 32'(req0_ready & req1_ready), 32'd0);
    @(posedge clk);
    #1;
    if (idx == 0) req0_valid = 1'b0;
    else          req1_valid = 1'b0;
    next_pref = 1 - idx;
    lat = 0;
    while (!(rsp0_valid || rsp1_valid) && lat < 40) begin
      if (clr_cap && lat == MC - 1) clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      lat++;
    end
    check("latency", 32'(lat), 32'(MC));
    check("rsp_owner", 32'(rsp1_valid), 32'(idx));
    check("rsp_other_low", 32'(rsp0_valid & rsp1_valid), 32'd0);
    check("result", rsp_result, er);
    check("ovf", 32'(rsp_overflow), 32'(eo));
    check("unf", 32'(rsp_underflow), 32'(eu));
    if (clr_cap) begin
      exp_sov = eo;
      exp_sun = eu;
    end else begin
      exp_sov = exp_sov | eo;
      exp_sun = exp_sun | eu;
    end
    check("sticky_ovf", 32'(sticky_ovf), 32'(exp_sov));
    check("sticky_unf", 32'(sticky_unf), 32'(exp_sun));
    check("busy_done", 32'(busy), 32'd1);
    held = rsp_result;
    d = (bp < 0) ? int'($urandom_range(0, 3)) : bp;
    for (int i = 0; i < d; i++) begin
      if (idx == 0) rsp1_ready = 1'b1;
      else          rsp0_ready = 1'b1;
      tick();
      check("hold_valid", 32'(idx == 0 ? rsp0_valid : rsp1_valid), 32'd1);
      check("hold_result", rsp_result, held);
      check("no_grant_in_done", 32'(req0_ready | req1_ready), 32'd0);
    end
    rsp0_ready = (idx == 0);
    rsp1_ready = (idx == 1);
    check("no_grant_at_ack", 32'(req0_ready | req1_ready), 32'd0);
    tick();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    check("rsp_drop", 32'(rsp0_valid | rsp1_valid), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("result_kept", rsp_result, held);
  endtask

  task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b);
    ra[idx] = a;
    rb[idx] = b;
    if (idx == 0) begin
      req0_a = a; req0_b = b; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_valid = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    logic [1:0] m;
    int         f;
    logic       any_rsp;

    vt[0] = '{32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0, 1'b0};
    vt[1] = '{32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b0, 1'b0};
    vt[2] = '{32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1'b1, 1'b0};
    vt[3] = '{32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b0, 1'b1};
    vt[4] = '{32'h0000_0000, 32'h40A0_0000, 32'h0000_0000, 1'b0, 1'b0};
    vt[5] = '{32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 1'b0, 1'b0};
    vt[6] = '{32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 1'b0, 1'b0};
    vt[7] = '{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1'b0};
    vt[8] = '{32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 1'b0, 1'b0};
    vt[9] = '{32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, 1'b0, 1'b0};

    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0; clr_flags = 1'b0;
    exp_sov = 1'b0; exp_sun = 1'b0; next_pref = 0; last_wait = 0;
    repeat (3) tick();
    req0_valid = 1'b1;
    #1;
    check("ready_in_reset", 32'(req0_ready), 32'd0);
    req0_valid = 1'b0;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ready", 32'({req0_ready, req1_ready}), 32'd0);
    check("reset_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    check("reset_sticky", 32'({sticky_ovf, sticky_unf}), 32'd0);
    check("reset_result", rsp_result, 32'd0);
    rst = 1'b0;
    tick();

    // Single multiply on requester 0: ready in the first IDLE cycle.
    set_req(0, 32'h4000_0000, 32'h4040_0000);
    serve(0, 32'h40C0_0000, 1'b0, 1'b0, 1'b0, 0);
    check("first_idle_ready", 32'(last_wait), 32'd0);

    for (int i = 0; i < 10; i++) begin
      set_req(i % 2, vt[i].a, vt[i].b);
      serve(i % 2, vt[i].r, vt[i].o, vt[i].u, 1'b0, -1);
    end

    // Contention: both valid every cycle, grants must alternate.
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    exp_sov = 1'b0; exp_sun = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_req(0, 32'h3FC0_0000, 32'h3FC0_0000);
      set_req(1, 32'h4000_0000, 32'h4040_0000);
      f = next_pref;
      serve(f, (f == 0) ? 32'h4010_0000 : 32'h40C0_0000, 1'b0, 1'b0, 1'b0, -1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Response backpressure with the other requester waiting.
    set_req(0, 32'h4000_0000, 32'h4000_0000);
    set_req(1, 32'h4040_0000, 32'h4040_0000);
    f = next_pref;
    serve(f, (f == 0) ? 32'h4080_0000 : 32'h4110_0000, 1'b0, 1'b0, 1'b0, 5);
    serve(1 - f, (f == 0) ? 32'h4110_0000 : 32'h4080_0000, 1'b0, 1'b0, 1'b0, 0);

    // Sticky flags and clear-versus-capture priority.
    set_req(0, 32'h7F00_0000, 32'h7F00_0000);
    serve(0, 32'h7F80_0000, 1'b1, 1'b0, 1'b0, 0);
    set_req(1, 32'h4000_0000, 32'h4040_0000);
    serve(1, 32'h40C0_0000, 1'b0, 1'b0, 1'b0, 0);
    set_req(0, 32'h4000_0000, 32'h4040_0000);
    serve(0, 32'h40C0_0000, 1'b0, 1'b0, 1'b1, 0);
    set_req(1, 32'h7F00_0000, 32'h7F00_0000);
    serve(1, 32'h7F80_0000, 1'b1, 1'b0, 1'b1, 0);
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    exp_sov = 1'b0;
    check("clr_idle", 32'(sticky_ovf), 32'd0);

    // Random traffic against the models.
    for (int it = 0; it < 25; it++) begin
      m = 2'($urandom_range(1, 3));
      ra[0] = rnd_fp(); rb[0] = rnd_fp(); ra[1] = rnd_fp(); rb[1] = rnd_fp();
      req0_a = ra[0]; req0_b = rb[0]; req1_a = ra[1]; req1_b = rb[1];
      req0_valid = m[0]; req1_valid = m[1];
      if (m == 2'b11) begin
        f = next_pref;
        serve(f, ref_mul(ra[f], rb[f]), 1'b0, 1'b0, 1'b0, -1);
        serve(1 - f, ref_mul(ra[1-f], rb[1-f]), 1'b0, 1'b0, 1'b0, -1);
      end else begin
        f = m[1] ? 1 : 0;
        serve(f, ref_mul(ra[f], rb[f]), 1'b0, 1'b0, 1'b0, -1);
      end
    end

    // Reset one cycle after a grant: the operation vanishes, pointer returns to requester 0.
    set_req(1, 32'h4000_0000, 32'h4040_0000);
    #1;
    check("pre_reset_grant", 32'(req1_ready), 32'd1);
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_sov = 1'b0; exp_sun = 1'b0; next_pref = 0;
    check("midexec_busy", 32'(busy), 32'd0);
    check("midexec_result", rsp_result, 32'd0);
    any_rsp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      any_rsp = any_rsp | rsp0_valid | rsp1_valid;
    end
    check("midexec_no_rsp", 32'(any_rsp), 32'd0);
    set_req(0, 32'h3FC0_0000, 32'h4000_0000);
    set_req(1, 32'h4040_0000, 32'h4040_0000);
    serve(0, 32'h4040_0000, 1'b0, 1'b0, 1'b0, 0);
    serve(1, 32'h4110_0000, 1'b0, 1'b0, 1'b0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/fp_mult_arbiter.md
Name: fp_mult_arbiter

Overview:
- Shares one combinational single-precision `multiplier` instance between two requesters.
- Arbitration is round-robin, with valid/ready handshakes on both the request and response sides.
- Operands are registered at grant. The multiplier is given MC_CYCLES clock cycles as a multicycle path, then the result and flags are captured and held until the owning requester accepts them.
- Sits between the FPU issue logic and the multiplier datapath; also keeps sticky exception flags.

Parameters:
- MC_CYCLES, 2, cycles allowed for the combinational multiply to settle; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operand pair
- req0_ready  out  1  requester 0 operand pair accepted this cycle
- req0_a  in  32  requester 0 operand A, IEEE-754 single
- req0_b  in  32  requester 0 operand B
- req1_valid  in  1  requester 1 has an operand pair
- req1_ready  out  1  requester 1 operand pair accepted this cycle
- req1_a  in  32  requester 1 operand A
- req1_b  in  32  requester 1 operand B
- rsp0_valid  out  1  result belongs to requester 0 and is valid
- rsp0_ready  in  1  requester 0 accepts result
- rsp1_valid  out  1  result belongs to requester 1 and is valid
- rsp1_ready  in  1  requester 1 accepts result
- rsp_result  out  32  product, shared by both response channels
- rsp_overflow  out  1  overflow flag of this product
- rsp_underflow  out  1  underflow flag of this product
- busy  out  1  high in any state other than IDLE
- clr_flags  in  1  clears the sticky flags
- sticky_ovf  out  1  sticky OR of all captured overflow flags
- sticky_unf  out  1  sticky OR of all captured underflow flags

Behaviour:
- Reset values (rst high at a clk edge, from any state, including mid-EXEC or DONE):
  - state=IDLE; priority pointer=0; owner=0; cycle counter=0.
  - rsp0_valid=rsp1_valid=0; rsp_result=0; rsp_overflow=rsp_underflow=0.
  - sticky_ovf=sticky_unf=0; busy=0.
  - An in-flight operation is discarded and no response is produced for it.
- req ready rules:
  - reqX_ready is asserted only in IDLE, never while rst=1, and only for the granted requester.
  - reqX_ready may depend combinationally on reqX_valid.
- Grant rules in IDLE:
  - Only one valid: that requester is granted.
  - Both valid: the requester selected by the priority pointer is granted.
  - Neither valid: no grant, stay in IDLE.
- On a grant edge:
  - Latch the operands into op_a/op_b.
  - owner <= granted index.
  - Priority pointer <= the other index.
  - counter <= MC_CYCLES-1.
  - state <= EXEC.
- EXEC:
  - The multiplier inputs are driven only from op_a/op_b, never from the request ports.
  - If counter≠0: decrement counter.
  - If counter=0: capture multiplier result/overflow/underflow into rsp_result/rsp_overflow/rsp_underflow; set rsp<owner>_valid; state <= DONE.
- Latency: a handshake at edge N gives rspX_valid=1 after edge N+MC_CYCLES.
- DONE:
  - rsp outputs are held stable.
  - The non-owner's rsp_valid stays 0.
  - The non-owner's rsp_ready is ignored.
  - When rsp<owner>_ready=1 at an edge: drop rsp<owner>_valid, state <= IDLE.
  - No new grant happens in the same cycle as the response handshake, so minimum issue interval is MC_CYCLES+2 cycles.
  - rsp_result and flags keep their last value after the handshake.
- Request stability: a requester that is valid but not ready keeps its valid and operands stable. The arbiter does not check this.
- Sticky flags:
  - At the capture edge: sticky_ovf |= overflow; sticky_unf |= underflow.
  - clr_flags=1 clears both sticky flags.
  - If clr_flags coincides with a capture edge, the capture wins: flag = captured value, old history cleared.
- Counter width is 4 bits. MC_CYCLES=1 means capture on the first EXEC edge.

Test Plan:
- Reset → busy=0, both ready=0 with no valid, rsp_valids=0, stickies=0, rsp_result=0.
- Single multiply:
  - Stimulus: req0 valid, A=0x40000000 (2.0), B=0x40400000 (3.0).
  - Response: req0_ready high in the first IDLE cycle; rsp0_valid after exactly MC_CYCLES edges; rsp_result=0x40C00000; ovf=unf=0; rsp1_valid=0.
- Contention round-robin:
  - Stimulus: both valid every cycle; req0=1.5×1.5 (0x3FC00000 each); req1=2.0×3.0.
  - Response: grants alternate 0,1,0,1; results 0x40100000 on rsp0 and 0x40C00000 on rsp1.
- Response backpressure: hold rsp0_ready=0 for 5 cycles → rsp0_valid and rsp_result stable, no new grant while req1 is valid; accept → IDLE, then req1 granted.
- Exception flags:
  - Stimulus: A=B=0x7F000000, then clr_flags together with a capture edge of a normal multiply.
  - Response: rsp_overflow=1 and sticky_ovf=1; sticky_ovf stays 1 afterwards; the clr_flags at the normal capture gives sticky_ovf=0.
- Reset mid-EXEC: assert rst one cycle after a grant → no rsp_valid is ever produced for that operation; the next request is serviced normally, and requester 0 wins a tie.
